mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, variable-latency memory between the instruction-fetch requester and the data-access requester of the pipelined ARM core. It sits between the Fetch/Memory stages and a unified instruction/data memory. Each request is registered, data access has priority with bounded fetch starvation, and one transaction is in flight at a time. The Ack pulses it returns drive the core's fetch and memory-stage stall logic.

## Interface
- AW, 32, address width
- DW, 32, data width
- STREAK, 4, maximum consecutive data grants while IReq is pending before fetch is forced (1..15)

- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- IReq  in  1  fetch request, held until IAck
- IAddr  in  AW  fetch address
- IAck  out  1  one-cycle pulse, fetch complete
- IRData  out  DW  fetch data, valid while IAck=1
- DReq  in  1  data request, held until DAck
- DWE  in  1  1 = write, 0 = read
- DAddr  in  AW  data address
- DWData  in  DW  write data
- DAck  out  1  one-cycle pulse, data access complete
- DRData  out  DW  read data, valid while DAck=1 after a read
- MemReq  out  1  memory request, held until MemAck
- MemWE  out  1  memory write enable
- MemAddr  out  AW  memory address
- MemWData  out  DW  memory write data
- MemRData  in  DW  memory read data, valid when MemAck=1
- MemAck  in  1  memory completion, may assert in the first MemReq cycle
- Busy  out  1  1 while the state is not IDLE
- SpuriousAck  out  1  sticky flag: MemAck was seen while MemReq=0

## Operation
- FSM states: IDLE, MEM_I, MEM_D, RESP.
- IDLE, grant decision:
  - DReq=1 and not (IReq=1 and streak==STREAK): go to MEM_D.
  - Otherwise, if IReq=1: go to MEM_I.
  - No request: stay in IDLE.
- On the grant edge, latch the winner's address into MemAddr. For data, also latch DWE into MemWE and DWData into MemWData. MemWE is always 0 for fetch.
- MEM_I / MEM_D:
  - MemReq=1 and all Mem* outputs are held stable.
  - On MemAck=1, go to RESP.
  - On a read, capture MemRData into IRData or DRData.
- RESP:
  - Exactly one of IAck or DAck is 1, and MemReq=0.
  - Requests are not sampled. Next state is IDLE.
- Streak counter (4 bits, saturates at STREAK):
  - Data grant with IReq=1: increment.
  - Data grant with IReq=0: clear.
  - Fetch grant: clear.
- On a write, DRData keeps its previous value. IRData and DRData hold their values between acks.
- SpuriousAck is set when MemAck=1 while the state is IDLE or RESP. It is cleared only by Reset.
- If a requester drops Req in the middle of a transaction, the transaction still completes and Ack still pulses.

## Timing
- Reset values:
  - State IDLE, streak 0.
  - MemReq, MemWE, IAck, DAck, Busy, SpuriousAck all 0.
  - MemAddr, MemWData, IRData, DRData all 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Cycle sequence:
  - Request sampled in IDLE at cycle 0.
  - MemReq=1 from cycle 1.
  - MemAck at cycle k (k ≥ 1).
  - Ack pulse at k+1.
  - IDLE at k+2.
- Back-to-back minimum period is 3 cycles, reached when MemAck arrives in the first MemReq cycle.
- Requesters must drop Req or present a new request in the cycle after Ack. RESP guarantees that a held Req is not re-issued.
- IReq and DReq in the same IDLE cycle: data wins unless streak==STREAK.
- Reset asserted mid-transaction: return to reset values immediately (asynchronously). A late MemAck after release sets SpuriousAck and is otherwise ignored.

## Test plan
- Single fetch:
  - Stimulus: IReq=1, IAddr=0x100; memory acks one cycle after MemReq with 0xE3A00001.
  - Required: MemReq at cycle 1, MemAddr=0x100, MemWE=0; IAck=1 and IRData=0xE3A00001 at cycle 3; Busy low at cycle 4.
- Data write:
  - Stimulus: DReq=1, DWE=1, DAddr=0x804, DWData=0xDEADBEEF; memory acks in the first MemReq cycle.
  - Required: MemWE=1, MemWData=0xDEADBEEF; DAck at cycle 2; DRData unchanged.
- Simultaneous requests with STREAK=4:
  - Stimulus: IReq and DReq held continuously high.
  - Required: grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each fetch grant.
- Requester holding Req through Ack:
  - Stimulus: DReq held 1 cycle past DAck.
  - Required: exactly one memory transaction.
- Spurious ack:
  - Stimulus: MemAck=1 in IDLE.
  - Required: SpuriousAck=1 and stays 1 until Reset; no Ack pulse.
- Reset mid-operation:
  - Stimulus: Reset=0 while in MEM_D.
  - Required: MemReq, Busy, DAck all 0 in the same cycle; after release, a new IReq completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one single-port, variable-latency memory.
// Data access has priority, but fetch is forced after STREAK consecutive data grants.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int STREAK = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic          IAck,
  output logic [DW-1:0] IRData,
  input  logic          DReq,
  input  logic          DWE,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic          DAck,
  output logic [DW-1:0] DRData,
  output logic          MemReq,
  output logic          MemWE,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemAck,
  output logic          Busy,
  output logic          SpuriousAck
);

  typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} stateT;

  localparam logic [3:0] StreakMax = 4'(STREAK);

  stateT      state;
  logic [3:0] streak;
  logic       dataWins;

  // Fetch only overrides a pending data request once the data streak is exhausted.
  assign dataWins = DReq && !(IReq && (streak == StreakMax));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      streak      <= '0;
      MemReq      <= 1'b0;
      MemWE       <= 1'b0;
      MemAddr     <= '0;
      MemWData    <= '0;
      IAck        <= 1'b0;
      DAck        <= 1'b0;
      IRData      <= '0;
      DRData      <= '0;
      Busy        <= 1'b0;
      SpuriousAck <= 1'b0;
    end else begin
      IAck <= 1'b0;
      DAck <= 1'b0;
      if (MemAck && (state == IDLE || state == RESP))
        SpuriousAck <= 1'b1;
      case (state)
        IDLE: begin
          if (dataWins) begin
            state    <= MEM_D;
            MemReq   <= 1'b1;
            Busy     <= 1'b1;
            MemWE    <= DWE;
            MemAddr  <= DAddr;
            MemWData <= DWData;
            if (!IReq)
              streak <= '0;
            else if (streak < StreakMax)
              streak <= streak + 4'd1;
          end else if (IReq) begin
            state   <= MEM_I;
            MemReq  <= 1'b1;
            Busy    <= 1'b1;
            MemWE   <= 1'b0;
            MemAddr <= IAddr;
            streak  <= '0;
          end
        end
        MEM_I: begin
          if (MemAck) begin
            state  <= RESP;
            MemReq <= 1'b0;
            IAck   <= 1'b1;
            IRData <= MemRData;
          end
        end
        MEM_D: begin
          if (MemAck) begin
            state  <= RESP;
            MemReq <= 1'b0;
            DAck   <= 1'b1;
            if (!MemWE)
              DRData <= MemRData;
          end
        end
        RESP: begin
          // Requests are ignored here so a Req still held through the Ack is not re-issued.
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data read/write, priority streak, spurious ack, reset.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IAck;
  logic [31:0] IRData;
  logic        DReq;
  logic        DWE;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic        DAck;
  logic [31:0] DRData;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;
  logic        Busy;
  logic        SpuriousAck;

  int testCount = 0;
  int failCount = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STREAK(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IRData(IRData),
    .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DWData(DWData),
    .DAck(DAck), .DRData(DRData),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck),
    .Busy(Busy), .SpuriousAck(SpuriousAck)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle; inputs are changed and outputs sampled 1ns after the rising edge.
  task automatic applyStimulus();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  logic [31:0] expAddr [10];
  logic [3:0]  expStreak [10];

  initial begin
    Reset = 1'b0; IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWE = 1'b0;
    DAddr = '0; DWData = '0; MemRData = '0; MemAck = 1'b0;
    #2;
    checkOutput("rst_MemReq", {31'b0, MemReq}, 32'd0);
    checkOutput("rst_Busy", {31'b0, Busy}, 32'd0);
    checkOutput("rst_Acks", {30'b0, IAck, DAck}, 32'd0);
    checkOutput("rst_Spurious", {31'b0, SpuriousAck}, 32'd0);
    checkOutput("rst_MemAddr", MemAddr, 32'd0);
    checkOutput("rst_RData", IRData | DRData, 32'd0);
    applyStimulus();
    Reset = 1'b1;
    applyStimulus();

    // Single fetch, memory acks one cycle after MemReq rises.
    IReq = 1'b1; IAddr = 32'h100;
    applyStimulus();
    checkOutput("f_MemReq_c1", {31'b0, MemReq}, 32'd1);
    checkOutput("f_MemAddr", MemAddr, 32'h100);
    checkOutput("f_MemWE", {31'b0, MemWE}, 32'd0);
    checkOutput("f_Busy_c1", {31'b0, Busy}, 32'd1);
    applyStimulus();
    checkOutput("f_IAck_c2", {31'b0, IAck}, 32'd0);
    MemAck = 1'b1; MemRData = 32'hE3A00001;
    applyStimulus();
    MemAck = 1'b0; IReq = 1'b0;
    checkOutput("f_IAck_c3", {31'b0, IAck}, 32'd1);
    checkOutput("f_IRData", IRData, 32'hE3A00001);
    checkOutput("f_MemReq_c3", {31'b0, MemReq}, 32'd0);
    applyStimulus();
    checkOutput("f_Busy_c4", {31'b0, Busy}, 32'd0);
    checkOutput("f_IAck_c4", {31'b0, IAck}, 32'd0);
    checkOutput("f_IRData_hold", IRData, 32'hE3A00001);

    // Data read with an immediate ack, to give DRData a known value.
    DReq = 1'b1; DWE = 1'b0; DAddr = 32'h808;
    applyStimulus();
    MemAck = 1'b1; MemRData = 32'hCAFEF00D;
    applyStimulus();
    MemAck = 1'b0; DReq = 1'b0;
    checkOutput("dr_DAck", {31'b0, DAck}, 32'd1);
    checkOutput("dr_DRData", DRData, 32'hCAFEF00D);
    applyStimulus();

    // Data write acked in the first MemReq cycle; DRData must not change.
    DReq = 1'b1; DWE = 1'b1; DAddr = 32'h804; DWData = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("dw_MemWE", {31'b0, MemWE}, 32'd1);
    checkOutput("dw_MemWData", MemWData, 32'hDEADBEEF);
    checkOutput("dw_MemAddr", MemAddr, 32'h804);
    MemAck = 1'b1; MemRData = 32'h55555555;
    applyStimulus();
    MemAck = 1'b0; DReq = 1'b0; DWE = 1'b0;
    checkOutput("dw_DAck_c2", {31'b0, DAck}, 32'd1);
    checkOutput("dw_IAck_c2", {31'b0, IAck}, 32'd0);
    checkOutput("dw_DRData_kept", DRData, 32'hCAFEF00D);
    applyStimulus();
    checkOutput("dw_Busy_c3", {31'b0, Busy}, 32'd0);

    // Both requesters held high: D x4 then I, twice.
    expAddr = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200,
                32'h300, 32'h300, 32'h300, 32'h300, 32'h200};
    expStreak = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    IReq = 1'b1; IAddr = 32'h200; DReq = 1'b1; DWE = 1'b0; DAddr = 32'h300;
    for (int n = 0; n < 10; n++) begin
      applyStimulus();
      checkOutput($sformatf("arb_addr_%0d", n), MemAddr, expAddr[n]);
      checkOutput($sformatf("arb_streak_%0d", n), {28'b0, dut.streak}, {28'b0, expStreak[n]});
      MemAck = 1'b1; MemRData = 32'h1000 + n;
      applyStimulus();
      MemAck = 1'b0;
      checkOutput($sformatf("arb_ack_%0d", n), {30'b0, IAck, DAck},
                  (expAddr[n] == 32'h200) ? 32'd2 : 32'd1);
      applyStimulus();
    end
    IReq = 1'b0; DReq = 1'b0;
    applyStimulus();

    // DReq held one cycle past DAck must produce only one transaction.
    DReq = 1'b1; DAddr = 32'h40C;
    applyStimulus();
    MemAck = 1'b1; MemRData = 32'h0000ABCD;
    applyStimulus();
    MemAck = 1'b0;
    checkOutput("hold_DAck", {31'b0, DAck}, 32'd1);
    applyStimulus();
    DReq = 1'b0;
    checkOutput("hold_idle_Busy", {31'b0, Busy}, 32'd0);
    applyStimulus();
    checkOutput("hold_no_reissue", {30'b0, MemReq, Busy}, 32'd0);
    applyStimulus();
    checkOutput("hold_still_idle", {30'b0, MemReq, Busy}, 32'd0);

    // Spurious ack in IDLE.
    checkOutput("sp_before", {31'b0, SpuriousAck}, 32'd0);
    MemAck = 1'b1;
    applyStimulus();
    MemAck = 1'b0;
    checkOutput("sp_set", {31'b0, SpuriousAck}, 32'd1);
    checkOutput("sp_no_ack", {29'b0, IAck, DAck, Busy}, 32'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("sp_sticky", {31'b0, SpuriousAck}, 32'd1);

    // Reset while in MEM_D clears everything asynchronously.
    DReq = 1'b1; DWE = 1'b0; DAddr = 32'h500;
    applyStimulus();
    checkOutput("rm_in_MEM_D", {31'b0, MemReq}, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("rm_MemReq", {31'b0, MemReq}, 32'd0);
    checkOutput("rm_Busy", {31'b0, Busy}, 32'd0);
    checkOutput("rm_DAck", {31'b0, DAck}, 32'd0);
    checkOutput("rm_Spurious", {31'b0, SpuriousAck}, 32'd0);
    checkOutput("rm_DRData", DRData, 32'd0);
    DReq = 1'b0;
    applyStimulus();
    Reset = 1'b1;
    MemAck = 1'b1;
    applyStimulus();
    MemAck = 1'b0;
    checkOutput("rm_late_ack", {31'b0, SpuriousAck}, 32'd1);
    checkOutput("rm_late_no_ack", {29'b0, IAck, DAck, Busy}, 32'd0);

    // A fresh fetch after release completes normally.
    IReq = 1'b1; IAddr = 32'h104;
    applyStimulus();
    checkOutput("post_MemAddr", MemAddr, 32'h104);
    checkOutput("post_MemReq", {31'b0, MemReq}, 32'd1);
    MemAck = 1'b1; MemRData = 32'h12345678;
    applyStimulus();
    MemAck = 1'b0; IReq = 1'b0;
    checkOutput("post_IAck", {31'b0, IAck}, 32'd1);
    checkOutput("post_IRData", IRData, 32'h12345678);
    applyStimulus();
    checkOutput("post_Busy", {31'b0, Busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
